axi4_lite_master_bridge: RTL and testbench

AXI4_LITE_MASTER_BRIDGE -- requirements
Module: axi4_lite_master_bridge

---
 rtl/axi4_lite_master_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_axi4_lite_master_bridge.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master_bridge.sv
// Single-outstanding AXI4-Lite master bridge: one command in, one AXI read or write
// transaction out, and one response back on the rsp_* handshake.
module axi4_lite_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    busy,
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RESP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;
  logic [15:0]             err_count_q, err_count_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [1:0] code);
    if (code != 2'b00 && v != 16'hFFFF) return v + 16'd1;
    return v;
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    err_count_d = err_count_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          rsp_write_d = cmd_write;
          if (cmd_write) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        // Each channel retires on its own; the move to WR_B waits for both flags.
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_q && w_done_q) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end
      WR_B: begin
        if (bvalid) begin
          state_d     = RESP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = bresp;
          err_count_d = sat_inc(err_count_q, bresp);
        end
      end
      RD_AR: begin
        if (arready) begin
          state_d   = RD_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_R: begin
        if (rvalid) begin
          state_d     = RESP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata;
          rsp_resp_d  = rresp;
          err_count_d = sat_inc(err_count_q, rresp);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      err_count_q <= err_count_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign err_count = err_count_q;
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Bench for axi4_lite_master_bridge: behavioural AXI4-Lite slave with memory plus
// a response scoreboard fed at command time and drained by a response monitor.
module tb_axi4_lite_master_bridge;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic [15:0] err_count;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 aclk = ~aclk;

  axi4_lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .err_count(err_count),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // Slave: registered bvalid/rvalid, configurable response code and B hold-off.
  logic [1:0]  slave_resp;
  logic        hold_b;
  logic [31:0] mem [0:63];
  logic        s_aw_got, s_w_got;
  logic [31:0] s_awaddr, s_wdata, s_last_awaddr;
  logic [3:0]  s_wstrb;
  logic        aw_hs, w_hs;
  logic [31:0] cur_a, cur_d;
  logic [3:0]  cur_s;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign cur_a = aw_hs ? awaddr : s_awaddr;
  assign cur_d = w_hs ? wdata : s_wdata;
  assign cur_s = w_hs ? wstrb : s_wstrb;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      s_aw_got <= 1'b0; s_w_got <= 1'b0;
      s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_last_awaddr <= '0;
      bvalid <= 1'b0; bresp <= '0; rvalid <= 1'b0; rresp <= '0; rdata <= '0;
    end else begin
      if (aw_hs) begin s_aw_got <= 1'b1; s_awaddr <= awaddr; end
      if (w_hs) begin s_w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; end
      if ((s_aw_got || aw_hs) && (s_w_got || w_hs) && !bvalid && !hold_b) begin
        bvalid <= 1'b1;
        bresp  <= slave_resp;
        s_last_awaddr <= cur_a;
        for (int b = 0; b < 4; b++)
          if (cur_s[b]) mem[cur_a[7:2]][8*b +: 8] <= cur_d[8*b +: 8];
        s_aw_got <= 1'b0;
        s_w_got  <= 1'b0;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
      if (arvalid && arready && !rvalid) begin
        rvalid <= 1'b1;
        rdata  <= mem[araddr[7:2]];
        rresp  <= slave_resp;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // Beat counters, only ever written here; the main flow takes differences.
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_hi = 0;
  always @(posedge aclk) begin
    if (awvalid && awready) aw_cnt++;
    if (wvalid && wready) w_cnt++;
    if (bvalid && bready) b_cnt++;
    if (arvalid) ar_hi++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] d;
    logic [1:0]  r;
    logic [15:0] e;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] model_mem [0:63];
  logic [15:0] exp_err;

  // Response monitor: pops one expectation per completed response handshake.
  always @(negedge aclk) begin
    if (!areset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check_val("sb_unexpected_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("rsp_write", {63'd0, rsp_write}, {63'd0, e.w});
        check_val("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.d});
        check_val("rsp_resp", {62'd0, rsp_resp}, {62'd0, e.r});
        check_val("err_count", {48'd0, err_count}, {48'd0, e.e});
      end
    end
  end

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    exp_t e;
    int   t;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge aclk); t++; end
    if (!cmd_ready) check_val("cmd_accept_timeout", 64'd0, 64'd1);
    e.w = w;
    e.r = slave_resp;
    if (slave_resp != 2'b00 && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
    e.e = exp_err;
    if (w) begin
      e.d = '0;
      for (int b = 0; b < 4; b++)
        if (s[b]) model_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
    end else begin
      e.d = model_mem[a[7:2]];
    end
    sb.push_back(e);
    @(posedge aclk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(negedge aclk);
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) check_val("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain_rsp();
    int t = 0;
    while (rsp_valid && t < 50) begin @(negedge aclk); t++; end
    if (rsp_valid) check_val("rsp_drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, aw0, w0, b0, ar0;
    logic [31:0] hold_d;
    logic [1:0]  hold_r;
    areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    slave_resp = 2'b00; hold_b = 1'b0; exp_err = '0;
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    #1;
    check_val("rst_awvalid", {63'd0, awvalid}, 64'd0);
    check_val("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check_val("rst_err_count", {48'd0, err_count}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(posedge aclk);
    @(negedge aclk); areset = 1'b0;
    check_val("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // Zero-wait write then read-back.
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    send_cmd(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(lat);
    check_val("wr_latency", 64'(lat), 64'd4);
    drain_rsp();
    check_val("wr_aw_beats", 64'(aw_cnt - aw0), 64'd1);
    check_val("wr_w_beats", 64'(w_cnt - w0), 64'd1);
    check_val("wr_b_beats", 64'(b_cnt - b0), 64'd1);

    ar0 = ar_hi;
    send_cmd(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    wait_rsp(lat);
    check_val("rd_latency", 64'(lat), 64'd3);
    drain_rsp();
    check_val("rd_arvalid_cycles", 64'(ar_hi - ar0), 64'd1);

    // Partial strobes reach the slave intact.
    send_cmd(1'b1, 32'h0000_000C, 32'h1234_5678, 4'h5);
    wait_rsp(lat); drain_rsp();
    send_cmd(1'b0, 32'h0000_000C, 32'h0, 4'h0);
    wait_rsp(lat); drain_rsp();

    // W channel stalled while AW completes immediately.
    wready = 1'b0;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    send_cmd(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF);
    @(negedge aclk);
    check_val("stall_awvalid_c1", {63'd0, awvalid}, 64'd1);
    for (int c = 2; c <= 5; c++) begin
      @(negedge aclk);
      check_val("stall_awvalid_dropped", {63'd0, awvalid}, 64'd0);
      check_val("stall_wvalid_held", {63'd0, wvalid}, 64'd1);
      check_val("stall_wdata_stable", {32'd0, wdata}, 64'hA5A5_5A5A);
      check_val("stall_no_bready", {63'd0, bready}, 64'd0);
    end
    wready = 1'b1;
    wait_rsp(lat); drain_rsp();
    check_val("stall_aw_beats", 64'(aw_cnt - aw0), 64'd1);
    check_val("stall_w_beats", 64'(w_cnt - w0), 64'd1);
    check_val("stall_b_beats", 64'(b_cnt - b0), 64'd1);
    send_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    wait_rsp(lat); drain_rsp();

    // Error responses, then a write response held off by rsp_ready.
    slave_resp = 2'b01;
    send_cmd(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    wait_rsp(lat); drain_rsp();
    rsp_ready = 1'b0;
    send_cmd(1'b1, 32'h0000_0002, 32'h0BAD_F00D, 4'hF);
    wait_rsp(lat);
    hold_d = rsp_rdata; hold_r = rsp_resp;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      check_val("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check_val("hold_rsp_resp", {62'd0, rsp_resp}, 64'd1);
      check_val("hold_rsp_rdata", {32'd0, rsp_rdata}, {32'd0, hold_d});
      check_val("hold_rsp_write", {63'd0, rsp_write}, 64'd1);
      check_val("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    end
    check_val("hold_resp_first", {62'd0, hold_r}, 64'd1);
    #1 rsp_ready = 1'b1;
    drain_rsp();
    check_val("err_count_two", {48'd0, err_count}, 64'd2);
    check_val("awaddr_passthrough", {32'd0, s_last_awaddr}, 64'h2);
    slave_resp = 2'b00;

    // Reset while waiting for B.
    hold_b = 1'b1;
    send_cmd(1'b1, 32'h0000_0014, 32'h7777_1111, 4'hF);
    lat = 0;
    while (!bready && lat < 20) begin @(negedge aclk); lat++; end
    check_val("pre_reset_bready", {63'd0, bready}, 64'd1);
    check_val("pre_reset_err", {48'd0, err_count}, {48'd0, exp_err});
    areset = 1'b1;
    #1;
    check_val("arst_bready", {63'd0, bready}, 64'd0);
    check_val("arst_valids", {59'd0, awvalid, wvalid, arvalid, rready, rsp_valid}, 64'd0);
    check_val("arst_err_count", {48'd0, err_count}, 64'd0);
    check_val("arst_busy", {63'd0, busy}, 64'd0);
    sb.delete();
    exp_err = '0;
    hold_b = 1'b0;
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    @(posedge aclk);
    @(negedge aclk); areset = 1'b0;
    check_val("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    b0 = b_cnt;
    repeat (3) @(negedge aclk);
    check_val("post_rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
    check_val("post_rst_no_b", 64'(b_cnt - b0), 64'd0);

    send_cmd(1'b1, 32'h0000_0018, 32'hCAFE_0001, 4'hF);
    wait_rsp(lat); drain_rsp();
    send_cmd(1'b0, 32'h0000_0018, 32'h0, 4'h0);
    wait_rsp(lat);
    check_val("post_rst_rd_latency", 64'(lat), 64'd3);
    drain_rsp();

    repeat (2) @(negedge aclk);
    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
